ring_matcher: RTL and testbench

Flow-tracking ring that sits directly downstream of header extraction. Accepts one `pkHeadInfo` key per handshake and matches it against DEPTH resident `Ringslot` records. On a hit it counts the packet in the resident record; on a miss it installs a new record. Records displaced by installation or drained by flush are emitted as `Ringslot` on an output stream toward the heap/record stage.

---
 rtl/ring_matcher.sv | 158 +++++++++++++++
 tb/tb_ring_matcher.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_matcher.sv
// ring_matcher: flow-tracking ring of DEPTH records. Each accepted key either hits a
// resident record (its packet count goes up) or installs a new record at wr_ptr. A
// record displaced by an install, or drained by a flush, leaves through a one-entry
// output register.
module ring_matcher #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_key,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [52:0]            out_slot,
    output logic                   flush_done,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);
    localparam logic [PtrW:0]   OccOne  = (PtrW + 1)'(1);

    typedef struct packed {
        logic        valid;
        logic [15:0] nof;
        logic [3:0]  mf;
        logic [31:0] key;
    } slot_t;

    typedef enum logic [1:0] {StRun, StFlush, StDone} state_e;

    slot_t           slots_q [DEPTH];
    slot_t           slots_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] scan_ptr_q, scan_ptr_d;
    state_e          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    slot_t           out_slot_q, out_slot_d;
    logic [PtrW:0]   occ_q, occ_d;

    logic             out_free;
    logic             accept;
    logic             hit;
    logic [DEPTH-1:0] hit_vec;

    // The output register can take a new record when empty or being consumed.
    assign out_free   = !out_valid_q || out_ready;
    assign in_ready   = rst_n && (state_q == StRun) && out_free;
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign out_slot   = out_slot_q;
    assign occupancy  = occ_q;
    // Drain is complete once the last flushed record has left the output register.
    assign flush_done = (state_q == StDone) && !out_valid_q;

    // Parallel key compare against every valid slot; keys are unique, so at most one hit.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = slots_q[i].valid && (slots_q[i].key == in_key);
        end
    end
    assign hit = |hit_vec;

    // Next-state for ring contents, pointers, output register and FSM.
    always_comb begin
        slots_d     = slots_q;
        wr_ptr_d    = wr_ptr_q;
        scan_ptr_d  = scan_ptr_q;
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        out_slot_d  = out_slot_q;
        occ_d       = occ_q;

        case (state_q)
            StRun: begin
                if (accept) begin
                    // Age every valid slot; the hit slot instead counts the packet.
                    for (int i = 0; i < DEPTH; i++) begin
                        if (slots_q[i].valid) begin
                            if (hit_vec[i]) begin
                                if (slots_q[i].nof != 16'hFFFF) begin
                                    slots_d[i].nof = slots_q[i].nof + 16'd1;
                                end
                                slots_d[i].mf = 4'd0;
                            end else if (slots_q[i].mf != 4'hF) begin
                                slots_d[i].mf = slots_q[i].mf + 4'd1;
                            end
                        end
                    end
                    if (!hit) begin
                        // Victim leaves with its pre-update contents.
                        if (slots_q[wr_ptr_q].valid) begin
                            out_valid_d = 1'b1;
                            out_slot_d  = slots_q[wr_ptr_q];
                        end else begin
                            occ_d = occ_q + OccOne;
                        end
                        slots_d[wr_ptr_q] = '{valid: 1'b1, nof: 16'd1, mf: 4'd0, key: in_key};
                        wr_ptr_d          = wr_ptr_q + PtrOne;
                    end
                end
                if (flush) begin
                    state_d    = StFlush;
                    scan_ptr_d = '0;
                end
            end
            StFlush: begin
                if (out_free) begin
                    if (slots_q[scan_ptr_q].valid) begin
                        out_valid_d          = 1'b1;
                        out_slot_d           = slots_q[scan_ptr_q];
                        slots_d[scan_ptr_q]  = '0;
                        occ_d                = occ_q - OccOne;
                    end
                    scan_ptr_d = scan_ptr_q + PtrOne;
                    if (scan_ptr_q == LastIdx) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (!out_valid_q) begin
                    wr_ptr_d = '0;
                    state_d  = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // State registers; reset drops every record and any pending output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            scan_ptr_q  <= '0;
            state_q     <= StRun;
            out_valid_q <= 1'b0;
            out_slot_q  <= '0;
            occ_q       <= '0;
        end else begin
            slots_q     <= slots_d;
            wr_ptr_q    <= wr_ptr_d;
            scan_ptr_q  <= scan_ptr_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_slot_q  <= out_slot_d;
            occ_q       <= occ_d;
        end
    end

endmodule

// File: tb/tb_ring_matcher.sv
// tb_ring_matcher: directed scenarios plus randomized traffic, checked against a
// slot-array reference model and a queue of expected emitted records.
module tb_ring_matcher;

    localparam int DEPTH = 16;
    localparam int OccW  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic        v;
        logic [15:0] nof;
        logic [3:0]  mf;
        logic [31:0] key;
    } rec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_key = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [52:0]     out_slot;
    logic            flush_done;
    logic [OccW-1:0] occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    rec_t m_slot [DEPTH];
    int   m_wr;
    int   m_occ;
    rec_t exp_q [$];
    rec_t seen_q [$];
    rec_t mon_exp;

    ring_matcher #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_slot  (out_slot),
        .flush_done(flush_done),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) m_slot[i] = '0;
        m_wr  = 0;
        m_occ = 0;
        exp_q.delete();
    endfunction

    // Applies one accepted key; returns 1 when a record is displaced.
    function automatic bit m_accept(input logic [31:0] key);
        int   h = -1;
        rec_t victim;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_slot[i].v && m_slot[i].key == key) h = i;
        end
        if (h >= 0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!m_slot[i].v) continue;
                if (i == h) begin
                    if (int'(m_slot[i].nof) < 65535) m_slot[i].nof = m_slot[i].nof + 16'd1;
                    m_slot[i].mf = 4'd0;
                end else if (int'(m_slot[i].mf) < 15) begin
                    m_slot[i].mf = m_slot[i].mf + 4'd1;
                end
            end
            return 1'b0;
        end
        victim = m_slot[m_wr];
        for (int i = 0; i < DEPTH; i++) begin
            if (m_slot[i].v && int'(m_slot[i].mf) < 15) m_slot[i].mf = m_slot[i].mf + 4'd1;
        end
        m_slot[m_wr] = '{v: 1'b1, nof: 16'd1, mf: 4'd0, key: key};
        m_wr = (m_wr + 1) % DEPTH;
        if (victim.v) begin
            exp_q.push_back(victim);
            return 1'b1;
        end
        m_occ++;
        return 1'b0;
    endfunction

    function automatic void m_flush();
        for (int i = 0; i < DEPTH; i++) begin
            if (m_slot[i].v) exp_q.push_back(m_slot[i]);
            m_slot[i] = '0;
        end
        m_occ = 0;
        m_wr  = 0;
    endfunction

    // Scoreboard: every consumed record must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            seen_q.push_back(out_slot);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL emit_unexpected: got %h, expected no record", out_slot);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_slot !== mon_exp) begin
                    n_fail++;
                    $display("FAIL emit_record: got %h, expected %h", out_slot, mon_exp);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] key);
        int waited = 0;
        in_valid = 1'b1;
        in_key   = key;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL send_accept: key %h in_ready=%b, expected 1 within 50 cycles",
                     key, in_ready);
        end else begin
            void'(m_accept(key));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_flush(output int pulses);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        m_flush();
        tick();
        flush  = 1'b0;
        pulses = 0;
        for (int c = 0; c < DEPTH + 10; c++) begin
            @(negedge clk);
            if (flush_done) pulses++;
        end
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b flush_done=%b, expected 0 0 0",
                     in_ready, out_valid, flush_done);
        end
        n_checks++;
        if (out_slot !== 53'd0 || occupancy !== '0) begin
            n_fail++;
            $display("FAIL reset_data: out_slot=%h occupancy=%0d, expected 0 0",
                     out_slot, occupancy);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int   p;
        rec_t e0 = '{v: 1'b1, nof: 16'd2, mf: 4'd0, key: 32'hA};
        rec_t e1 = '{v: 1'b1, nof: 16'd1, mf: 4'd1, key: 32'hB};
        out_ready = 1'b1;
        send(32'hA);
        send(32'hB);
        send(32'hA);
        @(negedge clk);
        n_checks++;
        if (occupancy !== OccW'(2) || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_occ: occupancy=%0d out_valid=%b, expected 2 0",
                     occupancy, out_valid);
        end
        tick();
        seen_q.delete();
        do_flush(p);
        n_checks++;
        if (p != 1) begin
            n_fail++;
            $display("FAIL basic_flush_done: pulses=%0d, expected 1", p);
        end
        n_checks++;
        if (seen_q.size() != 2 || seen_q[0] !== e0 || seen_q[1] !== e1) begin
            n_fail++;
            $display("FAIL basic_records: got %0d records (%h), expected 2 (%h %h)",
                     seen_q.size(), seen_q.size() > 0 ? seen_q[0] : '0, e0, e1);
        end
        n_checks++;
        if (occupancy !== '0) begin
            n_fail++;
            $display("FAIL basic_occ_after_flush: occupancy=%0d, expected 0", occupancy);
        end
    endtask

    task automatic test_back_to_back();
        int   p;
        rec_t e = '{v: 1'b1, nof: 16'd3, mf: 4'd0, key: 32'h77};
        send(32'h77);
        send(32'h77);
        send(32'h77);
        seen_q.delete();
        do_flush(p);
        n_checks++;
        if (seen_q.size() != 1 || seen_q[0] !== e || p != 1) begin
            n_fail++;
            $display("FAIL b2b_record: got %0d records first=%h pulses=%0d, expected 1 %h 1",
                     seen_q.size(), seen_q.size() > 0 ? seen_q[0] : '0, e, p);
        end
    endtask

    task automatic test_evict();
        int   p;
        rec_t ev  = '{v: 1'b1, nof: 16'd1, mf: 4'hF, key: 32'h100};
        rec_t s0  = '{v: 1'b1, nof: 16'd1, mf: 4'h0, key: 32'h110};
        rec_t s1  = '{v: 1'b1, nof: 16'd1, mf: 4'hF, key: 32'h101};
        out_ready = 1'b1;
        for (int i = 0; i <= 16; i++) send(32'h100 + 32'(i));
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_slot !== ev) begin
            n_fail++;
            $display("FAIL evict_record: out_valid=%b out_slot=%h, expected 1 %h",
                     out_valid, out_slot, ev);
        end
        tick();
        seen_q.delete();
        do_flush(p);
        n_checks++;
        if (seen_q.size() != 16 || seen_q[0] !== s0 || seen_q[1] !== s1) begin
            n_fail++;
            $display("FAIL evict_slot0: %0d records first=%h, expected 16 first=%h second=%h",
                     seen_q.size(), seen_q.size() > 0 ? seen_q[0] : '0, s0, s1);
        end
        n_checks++;
        if (p != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL evict_drain: pulses=%0d pending=%0d, expected 1 0", p, exp_q.size());
        end
    endtask

    task automatic test_saturation();
        int   p;
        rec_t e = '{v: 1'b1, nof: 16'hFFFF, mf: 4'd0, key: 32'hCAFE};
        send(32'hCAFE);
        // 65533 hits bring NoF to 16'hFFFE; three more must stick at 16'hFFFF.
        for (int i = 0; i < 65533 + 3; i++) send(32'hCAFE);
        seen_q.delete();
        do_flush(p);
        n_checks++;
        if (seen_q.size() != 1 || seen_q[0] !== e) begin
            n_fail++;
            $display("FAIL nof_saturate: got %0d records first=%h, expected 1 %h",
                     seen_q.size(), seen_q.size() > 0 ? seen_q[0] : '0, e);
        end
    endtask

    task automatic test_backpressure();
        int   p;
        rec_t e200 = '{v: 1'b1, nof: 16'd1, mf: 4'hF, key: 32'h200};
        rec_t e201 = '{v: 1'b1, nof: 16'd1, mf: 4'hF, key: 32'h201};
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(32'h200 + 32'(i));
        out_ready = 1'b0;
        send(32'h300);
        in_valid = 1'b1;
        in_key   = 32'h301;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_slot !== e200 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: out_valid=%b out_slot=%h in_ready=%b, expected 1 %h 0",
                         out_valid, out_slot, in_ready, e200);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_same_cycle_accept: in_ready=%b, expected 1", in_ready);
        end else begin
            void'(m_accept(32'h301));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_slot !== e201) begin
            n_fail++;
            $display("FAIL bp_reload: out_valid=%b out_slot=%h, expected 1 %h",
                     out_valid, out_slot, e201);
        end
        tick();
        do_flush(p);
        n_checks++;
        if (p != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: pulses=%0d pending=%0d, expected 1 0", p, exp_q.size());
        end
    endtask

    task automatic test_random();
        int   p;
        bit   m_ov = 1'b0;
        logic exp_rdy;
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_key    = 32'h5000 + 32'($urandom_range(0, 23));
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_rdy = !m_ov || out_ready;
            n_checks++;
            if (occupancy !== OccW'(m_occ)) begin
                n_fail++;
                $display("FAIL rand_occ: cycle %0d occupancy=%0d, expected %0d",
                         cyc, occupancy, m_occ);
            end
            n_checks++;
            if (out_valid !== m_ov || in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_hs: cycle %0d out_valid=%b in_ready=%b, expected %b %b",
                         cyc, out_valid, in_ready, m_ov, exp_rdy);
            end
            if (m_ov && out_ready) m_ov = 1'b0;
            if (in_valid && exp_rdy) begin
                if (m_accept(in_key)) m_ov = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        do_flush(p);
        n_checks++;
        if (p != 1 || exp_q.size() != 0 || occupancy !== '0) begin
            n_fail++;
            $display("FAIL rand_drain: pulses=%0d pending=%0d occupancy=%0d, expected 1 0 0",
                     p, exp_q.size(), occupancy);
        end
    endtask

    task automatic test_reset_mid_flush();
        int p;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(32'h400 + 32'(i));
        out_ready = 1'b0;
        flush     = 1'b1;
        m_flush();
        tick();
        flush = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_flush_pending: out_valid=%b, expected 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_slot !== 53'd0
                || occupancy !== '0 || flush_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b out_slot=%h occ=%0d fd=%b, %s",
                     out_valid, in_ready, out_slot, occupancy, flush_done, "expected all 0");
        end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== '0) begin
            n_fail++;
            $display("FAIL after_reset: in_ready=%b out_valid=%b occupancy=%0d, expected 1 0 0",
                     in_ready, out_valid, occupancy);
        end
        seen_q.delete();
        do_flush(p);
        n_checks++;
        if (p != 1 || seen_q.size() != 0) begin
            n_fail++;
            $display("FAIL empty_flush: pulses=%0d records=%0d, expected 1 0", p, seen_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_evict();
        test_saturation();
        test_backpressure();
        test_random();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
